// File: rtl/mem_sig_pkg.sv
// mem_sig_pkg: shared FSM state type, signature constants and the CRC-32 word step.
package mem_sig_pkg;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

   localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] SUM_INIT = 32'h0000_0000;

   function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
      logic [31:0] c;
      c = crc ^ data;
      for (int i = 0; i < 32; i++) c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/mem_sig_accum.sv
// mem_sig_accum: signature accumulator; CRC-32 when MEM_SIG_READER_CRC_EN is defined, else wrap-around sum.
module mem_sig_accum
   import mem_sig_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        init_i,
   input  logic        upd_i,
   input  logic [31:0] data_i,
   output logic [31:0] next_o
);

`ifdef MEM_SIG_READER_CRC_EN
   localparam logic [31:0] INIT = CRC_INIT;
`else
   localparam logic [31:0] INIT = SUM_INIT;
`endif

   logic [31:0] acc_q, acc_d, step;

   always_comb begin
`ifdef MEM_SIG_READER_CRC_EN
      step = crc32_step(acc_q, data_i);
`else
      step = acc_q + data_i;
`endif
      acc_d = init_i ? INIT : upd_i ? step : acc_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) acc_q <= INIT;
      else acc_q <= acc_d;

   assign next_o = acc_d;

endmodule

// File: rtl/mem_sig_reader.sv
// mem_sig_reader: walks a RAM byte-address range one read per cycle and folds the words into a signature (MEM_SIG_READER_CRC_EN selects CRC-32).
module mem_sig_reader
   import mem_sig_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [ADDR_WIDTH-1:0] end_addr_i,
   output logic                  en_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  we_o,
   output logic [3:0]            be_o,
   output logic [31:0]           wdata_o,
   input  logic [31:0]           rdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [31:0]           sig_o,
   output logic [ADDR_WIDTH-1:0] count_o
);

   state_e                st_q, st_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, end_q, end_d, cnt_q, cnt_d;
   logic                  cap_q, cap_d, err_q, err_d;
   logic [31:0]           sig_q, sig_d, acc_next;
   logic                  ok, run, load, cap, last;

   always_comb begin
      ok     = start_addr_i[1:0] == 2'b00 && end_addr_i[1:0] == 2'b00 && end_addr_i >= start_addr_i;
      run    = st_q == READ || st_q == DRAIN;
      load   = st_q == IDLE && start_i && ok;
      cap    = cap_q && !abort_i;
      last   = addr_q == end_q;
      st_d   = st_q == IDLE  ? (load ? READ : IDLE)
             : run && abort_i ? IDLE
             : st_q == READ  ? (last ? DRAIN : READ)
             : st_q == DRAIN ? DONE : IDLE;
      // hold at the last address so the walk never wraps past the top word
      addr_d = load ? start_addr_i : (st_q == READ && !last) ? addr_q + ADDR_WIDTH'(4) : addr_q;
      end_d  = load ? end_addr_i : end_q;
      cap_d  = st_q == READ && !abort_i;
      cnt_d  = load ? '0 : cap ? cnt_q + ADDR_WIDTH'(1) : cnt_q;
      err_d  = st_q == IDLE && start_i && !ok;
      sig_d  = st_q == DRAIN && !abort_i ? acc_next : sig_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         st_q   <= IDLE;
         addr_q <= '0;
         end_q  <= '0;
         cnt_q  <= '0;
         cap_q  <= 1'b0;
         err_q  <= 1'b0;
         sig_q  <= '0;
      end else begin
         st_q   <= st_d;
         addr_q <= addr_d;
         end_q  <= end_d;
         cnt_q  <= cnt_d;
         cap_q  <= cap_d;
         err_q  <= err_d;
         sig_q  <= sig_d;
      end

   mem_sig_accum u_accum (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .init_i (load),
      .upd_i  (cap),
      .data_i (rdata_i),
      .next_o (acc_next)
   );

   assign en_o    = st_q == READ && !abort_i;
   assign addr_o  = addr_q;
   assign we_o    = 1'b0;
   assign be_o    = 4'hF;
   assign wdata_o = '0;
   assign busy_o  = run;
   assign done_o  = st_q == DONE;
   assign err_o   = err_q;
   assign sig_o   = sig_q;
   assign count_o = cnt_q;

endmodule

// File: doc/mem_sig_reader.md
# mem_sig_reader

Memory signature reader: the read-side initiator for a single port of the testbench dual-port RAM. On a start pulse it walks a word-aligned byte-address range, issues one read per cycle on the RAM's enable/address/byte-enable port, and captures each returned word one cycle later. It folds the words into a 32-bit signature and reports completion. The block sits in the core testbench beside the RAM and provides an end-of-test memory signature without backdoor access.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width of the RAM port (RAM word index = addr >> 2).

Ports (clock and reset first):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- abort_i  in  1  abandon the current walk; return to IDLE, no done
- start_addr_i  in  ADDR_WIDTH  first byte address, inclusive
- end_addr_i  in  ADDR_WIDTH  last byte address, inclusive
- en_o  out  1  RAM port enable
- addr_o  out  ADDR_WIDTH  RAM byte address
- we_o  out  1  write enable; constant 0
- be_o  out  4  byte enables; constant 4'hF
- wdata_o  out  32  constant 0
- rdata_i  in  32  RAM read data, valid the cycle after en_o
- busy_o  out  1  walk in progress
- done_o  out  1  one-cycle pulse; signature valid
- err_o  out  1  one-cycle pulse; start rejected
- sig_o  out  32  signature; held until next accepted start
- count_o  out  ADDR_WIDTH  words accumulated

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on start_i, check the request. If either address has bits [1:0] != 0, or end < start, pulse err_o for one cycle and stay in IDLE. Otherwise latch the range, load the accumulator init value, clear count_o, and go to READ.
- READ: en_o=1 and addr_o=current address each cycle. Add 4 after each issue. After issuing end_addr, go to DRAIN.
- A capture flag, delayed one cycle from en_o, qualifies rdata_i. Each captured word updates the accumulator and increments count_o.
- DRAIN: en_o=0. Capture the last word, then go to DONE.
- DONE: done_o=1 for one cycle, sig_o updated, then IDLE.
- abort_i in READ or DRAIN: go to IDLE next cycle. en_o drops immediately (combinational from state). Any in-flight capture is discarded. sig_o keeps its previous value and done_o is not asserted. abort_i in IDLE or DONE is ignored.
- start_i outside IDLE is ignored.
- Address arithmetic is ADDR_WIDTH bits with no wrap. end_addr at the top word is legal, and the walk stops before the counter overflows.
- count_o saturates only by construction: at most 2^(ADDR_WIDTH-2) words.

## Timing
- Reset values: en_o=0, addr_o=0, we_o=0, be_o=4'hF, wdata_o=0, busy_o=0, done_o=0, err_o=0, sig_o=0, count_o=0. State is IDLE.
- start_i accepted at edge 0. en_o is high in cycles 1..N (N = (end-start)/4+1). Data is captured at edges 2..N+1. done_o is high in cycle N+2.
- busy_o is high in cycles 1..N+1, i.e. in READ and DRAIN.
- err_o is high in cycle 1 after a rejected start.
- Reset mid-walk: all outputs return to reset values asynchronously.

## Configuration
- MEM_SIG_READER_CRC_EN defined: the signature is CRC-32.
  - Polynomial 0x04C11DB7, non-reflected, init 0xFFFFFFFF, no final XOR.
  - Each word is processed MSB-first, 32 bits per captured word.
- Not defined: the signature is the 32-bit wrap-around sum of captured words, init 0.

## Structure
- Package mem_sig_pkg holds:
  - the state enum type;
  - CRC_POLY and CRC_INIT constants;
  - SUM_INIT constant;
  - a function computing one 32-bit CRC step.
- One sub-module, mem_sig_accum: the accumulator register with load-init and update-enable. It selects CRC or sum under the macro.

## Test plan
- Sum build: RAM words 0x00..0x08 = 1, 2, 3; start=0x00, end=0x08 → en_o high 3 cycles at 0x00/0x04/0x08; done_o in cycle 5; sig_o=6; count_o=3.
- Single word: start=end=0x10, word = 0xFFFFFFFF → 1 en_o cycle; done_o in cycle 3; sum sig_o=0xFFFFFFFF. In the CRC build, compare against the reference model.
- Rejects: start=0x02, or start=0x20 with end=0x10 → err_o pulse in cycle 1, en_o never asserted, sig_o unchanged.
- Abort: start=0x00, end=0x3C, abort_i in cycle 4 → en_o low from cycle 4, IDLE in cycle 5, no done_o, sig_o keeps its old value.
- Top of memory: ADDR_WIDTH=8, start=0xF8, end=0xFC → 2 reads; addr_o never wraps to 0x00; count_o=2.
- Reset during READ: rst_ni low mid-walk → all outputs at reset values. A fresh start afterwards completes normally.
